// File: rtl/fifo_rd_stream_if.sv
// Valid/ready stream bundle leaving the
// FIFO read stage toward the next block.
interface fifo_rd_stream_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_valid;
  logic                  out_ready;

  modport master (
    output out_data,
    output out_valid,
    input  out_ready
  );

  modport slave (
    input  out_data,
    input  out_valid,
    output out_ready
  );
endinterface

// File: rtl/fifo_rd_stream.sv
// FIFO read stage: prefetches reads, absorbs
// read latency, streams out, flushes, counts.
module fifo_rd_stream #(
  parameter int DATA_WIDTH = 8,
  parameter int RD_LATENCY = 1,
  parameter int BUF_DEPTH  = 3,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic                  flush,
  input  logic                  cnt_clr,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_q,
  output logic                  fifo_rdreq,
  fifo_rd_stream_if.master      strm,
  output logic                  flush_busy,
  output logic                  flush_done,
  output logic [CNT_WIDTH-1:0]  beat_cnt,
  output logic [CNT_WIDTH-1:0]  drop_cnt
);

  localparam int PW =
    (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int CW = $clog2(BUF_DEPTH + 1);
  localparam logic [PW-1:0] PTR_LAST =
    PW'(BUF_DEPTH - 1);
  localparam logic [CW-1:0] CNT_FULL =
    CW'(BUF_DEPTH);

  typedef enum logic {
    S_RUN,
    S_FLUSH
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [DATA_WIDTH-1:0] r_buf [BUF_DEPTH];
  logic [PW-1:0]         r_head;
  logic [PW-1:0]         r_tail;
  logic [CW-1:0]         r_count;
  logic [RD_LATENCY-1:0] r_vld;
  logic [CNT_WIDTH-1:0]  r_beat;
  logic [CNT_WIDTH-1:0]  r_drop;

  logic [31:0]           w_inflight;
  logic [31:0]           w_occ;
  logic [31:0]           w_drop_add;
  logic [CNT_WIDTH:0]    w_drop_sum;
  logic                  w_ret;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_valid;
  logic                  w_rdreq;
  logic                  w_clear;
  logic                  w_done;

  // Outstanding reads plus buffered entries
  always_comb begin
    w_inflight = '0;
    for (int i = 0; i < RD_LATENCY; i++)
      w_inflight = w_inflight + 32'(r_vld[i]);
    w_occ = 32'(r_count) + w_inflight;
  end

  assign w_ret   = r_vld[RD_LATENCY-1];
  assign w_valid = (r_state == S_RUN) &&
                   (r_count != '0);
  assign w_pop   = w_valid && strm.out_ready;

  // Next state, read issue and drop accounting
  always_comb begin
    w_state_nxt = r_state;
    w_rdreq     = 1'b0;
    w_push      = 1'b0;
    w_clear     = 1'b0;
    w_done      = 1'b0;
    w_drop_add  = '0;
    unique case (r_state)
      S_RUN: begin
        if (flush) begin
          w_clear     = 1'b1;
          w_state_nxt = S_FLUSH;
          w_drop_add  = 32'(r_count) -
                        32'(w_pop) +
                        32'(w_ret);
        end else begin
          w_rdreq = enable && !fifo_empty &&
                    (w_occ < 32'(BUF_DEPTH));
          w_push  = w_ret;
        end
      end
      S_FLUSH: begin
        w_rdreq    = !fifo_empty;
        w_drop_add = 32'(w_ret);
        if (fifo_empty && w_inflight == '0) begin
          w_done      = 1'b1;
          w_state_nxt = S_RUN;
        end
      end
      default: w_state_nxt = S_RUN;
    endcase
    w_rdreq = w_rdreq && rst_n;
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_RUN;
    else        r_state <= w_state_nxt;
  end

  // One bit per read travelling through the FIFO
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld <= '0;
    end else begin
      r_vld[0] <= w_rdreq;
      for (int i = 1; i < RD_LATENCY; i++)
        r_vld[i] <= r_vld[i-1];
    end
  end

  // Holding buffer ring with head/tail/count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      for (int i = 0; i < BUF_DEPTH; i++)
        r_buf[i] <= '0;
    end else if (w_clear) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_buf[r_tail] <= fifo_q;
        r_tail <= (r_tail == PTR_LAST) ?
                  '0 : r_tail + PW'(1);
      end
      if (w_pop)
        r_head <= (r_head == PTR_LAST) ?
                  '0 : r_head + PW'(1);
      if (w_push && !w_pop)
        r_count <= r_count + CW'(1);
      else if (!w_push && w_pop)
        r_count <= r_count - CW'(1);
    end
  end

  assign w_drop_sum = {1'b0, r_drop} +
                      (CNT_WIDTH+1)'(w_drop_add);

  // Saturating beat/drop statistics
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_beat <= '0;
      r_drop <= '0;
    end else begin
      if (cnt_clr)
        r_beat <= '0;
      else if (w_pop && r_beat != '1)
        r_beat <= r_beat + CNT_WIDTH'(1);
      if (cnt_clr)
        r_drop <= '0;
      else if (w_drop_sum[CNT_WIDTH])
        r_drop <= '1;
      else
        r_drop <= w_drop_sum[CNT_WIDTH-1:0];
    end
  end

  // A landing read must always find a free slot
  a_no_overflow : assert property (
    @(posedge clk) disable iff (!rst_n)
    !(w_push && r_count == CNT_FULL && !w_pop)
  );

  assign fifo_rdreq     = w_rdreq;
  assign strm.out_valid = w_valid;
  assign strm.out_data  = r_buf[r_head];
  assign flush_busy     = (r_state == S_FLUSH);
  assign flush_done     = w_done;
  assign beat_cnt       = r_beat;
  assign drop_cnt       = r_drop;

endmodule

// File: doc/fifo_rd_stream.md
Name: fifo_rd_stream

Overview:
- Downstream stage for the single-clock FIFO.
- Issues prefetch read requests into the FIFO and absorbs the fixed read latency in a small holding buffer.
- Presents the data as a valid/ready stream to the next pipeline block.
- Also provides a flush sequence that drains and discards all FIFO and buffered content, plus saturating beat and drop statistics.

Parameters:
DATA_WIDTH, 8, stream and FIFO data width
RD_LATENCY, 1, cycles from fifo_rdreq to valid fifo_q (1..3)
BUF_DEPTH, 3, holding buffer entries; must be >= RD_LATENCY+2 for one beat per cycle
CNT_WIDTH, 16, width of beat_cnt and drop_cnt

Ports:
clk  input  1  clock, all logic on rising edge
rst_n  input  1  asynchronous active-low reset
enable  input  1  permits new FIFO reads in RUN
flush  input  1  single-cycle flush request
cnt_clr  input  1  synchronous clear of beat_cnt and drop_cnt
fifo_empty  input  1  FIFO empty flag; updated the cycle after a read
fifo_q  input  DATA_WIDTH  FIFO read data, valid RD_LATENCY cycles after fifo_rdreq
fifo_rdreq  output  1  FIFO read request
out_data  output  DATA_WIDTH  stream data, equals buffer head
out_valid  output  1  stream valid
out_ready  input  1  stream ready from consumer
flush_busy  output  1  high while in FLUSH
flush_done  output  1  one-cycle pulse on FLUSH exit
beat_cnt  output  CNT_WIDTH  beats delivered (out_valid & out_ready), saturating
drop_cnt  output  CNT_WIDTH  entries discarded by flush, saturating

Behaviour:
- Reset (rst_n low, asynchronous): state=RUN, buffer count=0, latency pipe cleared, all outputs 0.
- In-flight tracking:
  - RD_LATENCY-deep valid shift register records each issued read.
  - inflight = number of set bits.
  - A return is written into the buffer tail when the last stage is set.
- RUN:
  - fifo_rdreq = enable & !fifo_empty & (count + inflight < BUF_DEPTH).
  - The registered count is used, excluding this cycle's pop, so there is no combinational path from out_ready to fifo_rdreq.
  - out_valid = (count != 0).
  - out_data = head entry; holds stable while out_valid & !out_ready.
- Simultaneous push and pop: count unchanged; head and tail pointers both advance, modulo BUF_DEPTH.
- Return arriving with count == BUF_DEPTH and no pop is impossible by construction; assert on it.
- enable low: no new requests; in-flight returns still land; the buffer keeps delivering.
- flush sampled high in RUN:
  - At that edge: buffer cleared, drop_cnt += count, state goes to FLUSH.
  - fifo_rdreq is not issued in that cycle.
- FLUSH:
  - flush_busy=1, out_valid=0.
  - fifo_rdreq = !fifo_empty; enable is ignored.
  - Every return is discarded with drop_cnt += 1.
  - flush input ignored.
- Exit FLUSH when fifo_empty & inflight==0 & !fifo_rdreq: flush_done=1 for one cycle, state goes to RUN on the same edge, flush_busy=0.
- Returns that were in flight when flush is sampled are counted as drops.
- Counters:
  - Increments are 0 or 1 per cycle; drop_cnt adds count (0..BUF_DEPTH) at flush entry.
  - Both counters saturate at all-ones.
  - cnt_clr wins over a same-cycle increment (result 0).
- Reset mid-flush: returns immediately to the reset state; flush_done is not pulsed.
- fifo_rdreq is never asserted while fifo_empty=1, so the FIFO is never underflowed.

Test Plan:
- Reset, FIFO preloaded with 0x10..0x17, out_ready=1, RD_LATENCY=1, BUF_DEPTH=3 -> first fifo_rdreq the cycle after reset release; out_data 0x10..0x17 on 8 consecutive cycles; beat_cnt=8; fifo_rdreq never high with fifo_empty=1.
- Same load, out_ready=0 -> buffer fills; fifo_rdreq stops after 3 reads; out_data holds 0x10. Then out_ready=1 -> order 0x10..0x17, no gaps after restart.
- Random out_ready toggling, 256 beats, RD_LATENCY=3, BUF_DEPTH=5 -> output sequence equals input sequence; count+inflight never exceeds 5.
- 20 entries in FIFO, 3 delivered, flush pulse with 2 buffered and 1 in flight -> out_valid=0 next cycle; FIFO drained; drop_cnt=17; single flush_done pulse; flush_busy low afterwards.
- drop_cnt preset near 0xFFFF via repeated flushes, then another flush of 5 entries -> drop_cnt=0xFFFF. cnt_clr asserted during a delivery beat -> beat_cnt=0.
- rst_n asserted during FLUSH with returns in flight -> all outputs 0 immediately, no flush_done. After release, new data streams correctly.
